// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: operation modes,
// burst FSM states and a helper that classifies the shift/rotate modes.
package usr_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_UP   = 3'b110,
    MODE_DOWN = 3'b111
  } mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  // Only these four modes are repeatable as a multi-cycle burst.
  function automatic logic is_shift_mode(input mode_e m);
    return m inside {MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR};
  endfunction

endpackage

// File: rtl/usr_if.sv
// Control/data bundle of the universal shift register; the master side drives
// the operation request, the slave side returns register contents and status.
interface usr_if #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
);
  logic             En;
  logic [2:0]       Mode;
  logic [WIDTH-1:0] D;
  logic             SI_L;
  logic             SI_R;
  logic             Start;
  logic [CW-1:0]    Amount;
  logic [WIDTH-1:0] Q;
  logic             SO_L;
  logic             SO_R;
  logic             Busy;
  logic             Done;
  logic             Carry;

  modport master (
    output En, Mode, D, SI_L, SI_R, Start, Amount,
    input  Q, SO_L, SO_R, Busy, Done, Carry
  );

  modport slave (
    input  En, Mode, D, SI_L, SI_R, Start, Amount,
    output Q, SO_L, SO_R, Busy, Done, Carry
  );
endinterface

// File: rtl/usr_burst_ctrl.sv
// Burst controller: IDLE/BURST FSM, saturating down-counter and Busy/Done.
// Tells the datapath each cycle whether to apply an operation, and which one.
module usr_burst_ctrl
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_en,
  input  logic          i_start,
  input  mode_e         i_mode,
  input  logic [CW-1:0] i_amount,
  output logic          o_op_stb,
  output mode_e         o_op_mode,
  output logic          o_busy,
  output logic          o_done
);

  localparam logic [CW-1:0] MAX_AMT = CW'(WIDTH);

  state_e        r_state;
  mode_e         r_mode;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;
  logic [CW-1:0] w_amount;

  assign w_amount = (i_amount > MAX_AMT) ? MAX_AMT : i_amount;

  // NOTE: every output of this always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    o_op_stb  = 1'b0;
    o_op_mode = i_mode;
    if (r_state == ST_BURST) begin
      o_op_stb  = 1'b1;
      o_op_mode = r_mode;
    end else if (i_start) begin
      o_op_stb = !is_shift_mode(i_mode);
    end else begin
      o_op_stb = i_en;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_HOLD;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (i_start && is_shift_mode(i_mode)) begin
            if (w_amount == '0) begin
              r_done <= 1'b1;
            end else begin
              r_mode  <= i_mode;
              r_cnt   <= w_amount;
              r_busy  <= 1'b1;
              r_state <= ST_BURST;
            end
          end
        end
        ST_BURST: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register: load, shift, rotate and modulo count in single
// steps, plus multi-cycle shift/rotate bursts sequenced by usr_burst_ctrl.
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input logic  Cp,
  input logic  Rst_n,
  usr_if.slave bus
);

  logic [WIDTH-1:0] r_q;
  logic             r_carry;
  logic [WIDTH-1:0] w_next;
  logic             w_op_stb;
  mode_e            w_op_mode;
  logic             w_wrap;
  logic             w_busy;
  logic             w_done;

  usr_burst_ctrl #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_burst_ctrl (
    .clk       (Cp),
    .rst_n     (Rst_n),
    .i_en      (bus.En),
    .i_start   (bus.Start),
    .i_mode    (mode_e'(bus.Mode)),
    .i_amount  (bus.Amount),
    .o_op_stb  (w_op_stb),
    .o_op_mode (w_op_mode),
    .o_busy    (w_busy),
    .o_done    (w_done)
  );

  always_comb begin
    w_next = r_q;
    unique case (w_op_mode)
      MODE_HOLD: w_next = r_q;
      MODE_LOAD: w_next = bus.D;
      MODE_SHL:  w_next = {r_q[WIDTH-2:0], bus.SI_R};
      MODE_SHR:  w_next = {bus.SI_L, r_q[WIDTH-1:1]};
      MODE_ROL:  w_next = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
      MODE_ROR:  w_next = {r_q[0], r_q[WIDTH-1:1]};
      MODE_UP:   w_next = r_q + WIDTH'(1);
      MODE_DOWN: w_next = r_q - WIDTH'(1);
      default:   w_next = r_q;
    endcase
  end

  // Carry flags the wrap of a count that is actually applied this edge.
  assign w_wrap = ((w_op_mode == MODE_UP)   && (&r_q)) ||
                  ((w_op_mode == MODE_DOWN) && (r_q == '0));

  always_ff @(posedge Cp) begin
    if (!Rst_n) begin
      r_q     <= '0;
      r_carry <= 1'b0;
    end else begin
      r_carry <= w_op_stb && w_wrap;
      if (w_op_stb) r_q <= w_next;
    end
  end

  assign bus.Q     = r_q;
  assign bus.SO_L  = r_q[WIDTH-1];
  assign bus.SO_R  = r_q[0];
  assign bus.Busy  = w_busy;
  assign bus.Done  = w_done;
  assign bus.Carry = r_carry;

endmodule
